// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: architectural width, canonical NOP and the
// instruction cache controller state type.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0 -- handed to fetch whenever the cache cannot supply a word
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      ICACHE_IDLE   = 1'b0,
      ICACHE_REFILL = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Combinational read of one line (valid, tag, selected word), one word write
// port, a tag write that can optionally mark the line valid, and flush-all.
// Only the valid bits carry reset; tag and data contents are don't-care
// until their line is marked valid.
module icache_line_array #(
   parameter int NB_LINES       = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_W          = 24,
   localparam int IDX_W         = $clog2(NB_LINES),
   localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [OFF_W-1:0] rd_off,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_data,
   input  logic             tag_we,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             set_valid,
   input  logic             flush_all
);

   logic [NB_LINES-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NB_LINES];
   logic [31:0]         data_q [NB_LINES][WORDS_PER_LINE];

   // valid bits: flush wins over a same-cycle set so a fill racing a flush stays invalid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
      end else if (flush_all) begin
         valid_q <= '0;
      end else if (set_valid) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // tag and data storage, deliberately unreset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_idx][wr_off] <= wr_data;
      end
      if (tag_we) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Hits are served combinationally;
// a miss stalls fetch and refills the whole line word by word over a
// req/ack memory port, keeping mem_req_o high until the last ack.
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   ICACHE_IDLE   | serve hits; a miss latches the line address and stalls
//   ICACHE_REFILL | request words of the latched line until the last ack
module icache
   import riscv_pkg::*;
#(
   parameter int NB_LINES       = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [XLEN-1:0] icache_adr_i,
   output logic [31:0]     icache_instr_o,
   output logic            icache_stall_o,
   input  logic            icache_flush_i,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_adr_o,
   input  logic            mem_ack_i,
   input  logic [31:0]     mem_data_i
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NB_LINES);
   localparam int TAG_W = XLEN - IDX_W - OFF_W - 2;

   icache_state_t    state_q, state_d;
   logic [OFF_W-1:0] word_cnt_q;
   logic             flush_pend_q;
   logic [XLEN-1:0]  line_base_q;
   logic [IDX_W-1:0] ref_idx_q;

   logic [OFF_W-1:0] adr_off;
   logic [IDX_W-1:0] adr_idx;
   logic [TAG_W-1:0] adr_tag;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             hit;
   logic             refill_ack;
   logic             last_ack;
   logic             unused_adr_bits;

   assign adr_off         = icache_adr_i[OFF_W+1:2];
   assign adr_idx         = icache_adr_i[IDX_W+OFF_W+1:OFF_W+2];
   assign adr_tag         = icache_adr_i[XLEN-1:IDX_W+OFF_W+2];
   assign unused_adr_bits = ^icache_adr_i[1:0];

   assign hit        = rd_valid && (rd_tag == adr_tag);
   assign refill_ack = (state_q == ICACHE_REFILL) && mem_ack_i;
   assign last_ack   = refill_ack && (word_cnt_q == OFF_W'(WORDS_PER_LINE - 1));

   icache_line_array #(
      .NB_LINES       (NB_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_W)
   ) u_lines (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_idx    (adr_idx),
      .rd_off    (adr_off),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (refill_ack),
      .wr_idx    (ref_idx_q),
      .wr_off    (word_cnt_q),
      .wr_data   (mem_data_i),
      .tag_we    (last_ack),
      .wr_tag    (line_base_q[XLEN-1:XLEN-TAG_W]),
      .set_valid (last_ack && !flush_pend_q && !icache_flush_i),
      .flush_all (icache_flush_i)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ICACHE_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: a redirect during refill is ignored until the line completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         ICACHE_IDLE:   if (!hit)     state_d = ICACHE_REFILL;
         ICACHE_REFILL: if (last_ack) state_d = ICACHE_IDLE;
      endcase
   end

   // outputs: NOP and stall unless an IDLE hit; request words only while refilling
   always_comb begin
      icache_instr_o = NOP_INSTR;
      icache_stall_o = 1'b1;
      mem_req_o      = 1'b0;
      mem_adr_o      = '0;
      case (state_q)
         ICACHE_IDLE: begin
            if (hit) begin
               icache_instr_o = rd_data;
               icache_stall_o = 1'b0;
            end
         end
         ICACHE_REFILL: begin
            mem_req_o = 1'b1;
            mem_adr_o = line_base_q | XLEN'({word_cnt_q, 2'b00});
         end
      endcase
   end

   // refill bookkeeping: latched line, word counter, and flush-during-refill flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         line_base_q  <= '0;
         ref_idx_q    <= '0;
      end else if (state_q == ICACHE_IDLE) begin
         flush_pend_q <= 1'b0;
         word_cnt_q   <= '0;
         if (!hit) begin
            line_base_q <= {adr_tag, adr_idx, {(OFF_W+2){1'b0}}};
            ref_idx_q   <= adr_idx;
         end
      end else begin
         if (mem_ack_i) begin
            word_cnt_q <= last_ack ? '0 : word_cnt_q + 1'b1;
         end
         if (last_ack) begin
            flush_pend_q <= 1'b0;
         end else if (icache_flush_i) begin
            flush_pend_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random
// fetch traffic, all compared against a line-level model of a direct-mapped
// cache (16 lines x 4 words) backed by a functional memory image.
module tb_icache;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] icache_adr_i;
   logic [31:0] icache_instr_o;
   logic        icache_stall_o;
   logic        icache_flush_i;
   logic        mem_req_o;
   logic [31:0] mem_adr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: line contents as the cache should hold them
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   logic [31:0] m_data  [16][4];

   icache dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .icache_adr_i   (icache_adr_i),
      .icache_instr_o (icache_instr_o),
      .icache_stall_o (icache_stall_o),
      .icache_flush_i (icache_flush_i),
      .mem_req_o      (mem_req_o),
      .mem_adr_o      (mem_adr_o),
      .mem_ack_i      (mem_ack_i),
      .mem_data_i     (mem_data_i)
   );

   always #5 clk = ~clk;

   // memory image: first line holds 0x11..0x44, everything else is address-derived
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a[31:4] == 28'h800_0000)
         return 32'h11 * ({30'b0, a[3:2]} + 32'd1);
      return a ^ 32'h3c5a_96e1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_flush();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   // One fetch at address a, starting and ending at a falling edge. On a miss the
   // memory side is played: the first word is acked in the first REFILL cycle,
   // later words after 'gap' idle cycles. flush_word pulses flush with that ack;
   // redir changes the fetch address in the cycle of the second ack.
   task automatic fetch(input logic [31:0] a, input int gap = 0, input int flush_word = -1,
                        input bit flush_idle = 1'b0, input logic [31:0] redir = 32'h0);
      int          idx, off, ncyc;
      logic [23:0] tg;
      logic [31:0] base;
      bit          hit, flushed, ack;
      idx  = int'(a[7:4]);
      off  = int'(a[3:2]);
      tg   = a[31:8];
      base = {a[31:4], 4'h0};
      hit  = m_valid[idx] && (m_tag[idx] == tg);
      icache_adr_i   = a;
      icache_flush_i = flush_idle;
      mem_ack_i      = 1'b0;
      #1;
      check("idle_stall", {31'b0, icache_stall_o}, {31'b0, !hit});
      if (hit) begin
         check("hit_instr", icache_instr_o, m_data[idx][off]);
      end else begin
         check("miss_instr", icache_instr_o, NOP_INSTR);
         check("miss_req", {31'b0, mem_req_o}, 32'd0);
      end
      if (flush_idle) model_flush();
      @(negedge clk);
      icache_flush_i = 1'b0;
      if (!hit) begin
         flushed = 1'b0;
         for (int w = 0; w < 4; w++) begin
            ncyc = (w == 0) ? 1 : gap + 1;
            for (int g = 0; g < ncyc; g++) begin
               ack            = (g == ncyc - 1);
               mem_ack_i      = ack;
               mem_data_i     = ack ? mem_val(base + 32'(4 * w)) : $urandom;
               icache_flush_i = ack && (w == flush_word);
               if (redir != 32'h0 && w == 1 && g == 0) icache_adr_i = redir;
               #1;
               check("refill_req", {31'b0, mem_req_o}, 32'd1);
               check("refill_adr", mem_adr_o, base + 32'(4 * w));
               check("refill_stall", {31'b0, icache_stall_o}, 32'd1);
               check("refill_instr", icache_instr_o, NOP_INSTR);
               if (icache_flush_i) begin
                  flushed = 1'b1;
                  model_flush();
               end
               @(negedge clk);
            end
         end
         mem_ack_i      = 1'b0;
         icache_flush_i = 1'b0;
         for (int k = 0; k < 4; k++) m_data[idx][k] = mem_val(base + 32'(4 * k));
         m_tag[idx] = tg;
         if (!flushed) m_valid[idx] = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] ra;
      int          rg, rf;
      bit          rfi;
      model_flush();
      reset_n        = 1'b0;
      icache_adr_i   = 32'h8000_0000;
      icache_flush_i = 1'b0;
      mem_ack_i      = 1'b0;
      mem_data_i     = 32'h0;
      #23;
      check("rst_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_adr", mem_adr_o, 32'h0);
      check("rst_stall", {31'b0, icache_stall_o}, 32'd1);
      check("rst_instr", icache_instr_o, NOP_INSTR);
      @(negedge clk);
      reset_n = 1'b1;

      // cold miss, then same line hits back to back
      fetch(32'h8000_0000);
      fetch(32'h8000_0000);
      check("cold_word0", icache_instr_o, 32'h0000_0011);
      fetch(32'h8000_0004);
      fetch(32'h8000_000C);

      // index conflict evicts the first line
      fetch(32'h8000_0100);
      fetch(32'h8000_0104);
      fetch(32'h8000_0000);

      // acks every third cycle
      fetch(32'h8000_0010, 2);
      fetch(32'h8000_0018);

      // flush in IDLE, then flush racing the 2nd refill word
      fetch(32'h8000_0010, 0, -1, 1'b1);
      fetch(32'h8000_0010);
      fetch(32'h8000_0020, 0, 1);
      fetch(32'h8000_0020);
      fetch(32'h8000_0024);

      // redirect after the first ack: line completes, new line refills right after
      fetch(32'h8000_0000, 0, -1, 1'b0, 32'h8000_0040);
      fetch(32'h8000_0040);
      fetch(32'h8000_0008);

      // flush with the last ack leaves the line invalid
      fetch(32'h8000_0050, 1, 3);
      fetch(32'h8000_0050);

      // reset in the middle of a refill
      fetch(32'h8000_0000, 0, -1, 1'b1);
      icache_adr_i = 32'h8000_0000;
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         mem_ack_i  = 1'b1;
         mem_data_i = mem_val(32'h8000_0000 + 32'(4 * w));
         @(negedge clk);
      end
      mem_ack_i = 1'b0;
      reset_n   = 1'b0;
      #1;
      check("midrst_req", {31'b0, mem_req_o}, 32'd0);
      check("midrst_adr", mem_adr_o, 32'h0);
      model_flush();
      @(negedge clk);
      reset_n = 1'b1;
      fetch(32'h8000_0000);
      fetch(32'h8000_0004);

      // random traffic over four tags so hits, conflicts and flushes mix
      for (int n = 0; n < 60; n++) begin
         ra  = 32'h8000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
             | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         rg  = int'($urandom_range(0, 2));
         rf  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
         rfi = ($urandom_range(0, 9) == 0);
         fetch(ra, rg, rf, rfi);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache.
- Serves as the responder on the fetch-side icache interface: address in, 32-bit instruction out.
- On a hit the instruction is returned combinationally in the same cycle, so the fetch stage can flop it.
- On a miss it raises a stall and refills one line from the instruction memory port using a word-by-word request/acknowledge handshake.

Parameters:
- XLEN, 32, address width (taken from riscv_pkg).
- NB_LINES, 16, number of cache lines; power of 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- icache_adr_i  input  XLEN  fetch address; bits [1:0] ignored.
- icache_instr_o  output  32  instruction at icache_adr_i; valid when icache_stall_o=0.
- icache_stall_o  output  1  miss or refill in progress; fetch holds its PC while high.
- icache_flush_i  input  1  single-cycle pulse (fence.i); invalidates all lines.
- mem_req_o  output  1  refill word request.
- mem_adr_o  output  XLEN  word-aligned refill address.
- mem_ack_i  input  1  one-cycle pulse; the requested word is present on mem_data_i.
- mem_data_i  input  32  refill data.

Behaviour:
- Address split: word offset = adr[OFF_W+1:2], index = adr[IDX_W+OFF_W+1:OFF_W+2], tag = remaining upper bits. OFF_W=log2(WORDS_PER_LINE), IDX_W=log2(NB_LINES). Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage: per-line valid bit, tag and data words. Only the valid bits are reset; tag and data are unreset.
- Hit = valid[index] & (tag_array[index]==tag). The hit path is combinational.
- FSM states: IDLE, REFILL.
- IDLE:
  - On a hit: icache_instr_o=data[index][offset], stall=0.
  - On a miss: stall=1 combinationally, icache_instr_o=NOP (0x00000013). Latch line base = {tag,index,0} and the index. Next state REFILL.
- REFILL:
  - stall=1, icache_instr_o=NOP, mem_req_o=1.
  - mem_adr_o = line base + word_cnt*4.
  - On each mem_ack_i: write mem_data_i to data[latched index][word_cnt], then word_cnt+1.
  - On the ack where word_cnt=WORDS_PER_LINE-1: write the tag, set valid, clear word_cnt, go to IDLE.
  - The following cycle re-evaluates the hit combinationally, so the same address hits with no extra bubble.
- Miss penalty: N+1 stalled cycles minimum (the miss-detect cycle plus N ack cycles, N=WORDS_PER_LINE), more when acks have gaps.
- mem_req_o stays high continuously until the last ack. It is never dropped between words.
- Address change during REFILL (redirect): the refill still completes for the latched line. The new address is evaluated in IDLE afterwards.
- Flush:
  - In IDLE: all valid bits are cleared at the clock edge.
  - During REFILL: all valid bits are cleared, a flush_pending flag is set, and the refill finishes without setting valid. This prevents stale fills.
  - A flush simultaneous with the last ack also leaves that line invalid.
- Index conflict: the refill overwrites the line; there is no victim handling (read-only).
- Reset, including mid-refill:
  - FSM=IDLE, word_cnt=0, flush_pending=0, all valid=0.
  - mem_req_o=0, mem_adr_o=0.
  - icache_stall_o reflects a miss combinationally as soon as reset_n releases. icache_instr_o=NOP while invalid.

Decomposition:
- riscv_pkg gains:
  - NOP_INSTR constant 32'h00000013.
  - typedef enum logic {ICACHE_IDLE, ICACHE_REFILL} icache_state_t.
- The XLEN-derived widths are computed locally from the parameters.
- One sub-module, icache_line_array: tag/valid/data storage with a combinational read port, a single word-write port, line-valid set, and flush-all. The FSM stays in icache.

Test Plan:
- Cold miss. Reset, then adr=0x80000000; mem acks every cycle with 0x11,0x22,0x33,0x44.
  - mem_adr_o sequence: 0x80000000, 04, 08, 0C.
  - stall high for 5 cycles, then instr=0x11 with stall=0.
  - Next cycle adr=0x80000004 gives 0x22 with no stall.
- Conflict. After the cold miss, adr=0x80000100 (same index, new tag).
  - Miss and refill from 0x80000100.
  - Returning to 0x80000000 misses again.
- Ack gaps. Acks arrive every third cycle.
  - mem_req_o stays high throughout and mem_adr_o advances only on ack.
  - stall lasts 1+3*4 cycles minus the trailing gap.
- Flush. Flush in IDLE after the fill makes 0x80000000 miss next cycle. Flush pulsed during the 2nd refill word: the refill completes, but the line is still invalid and misses again.
- Redirect mid-refill. Change adr to 0x80000040 after the first ack.
  - Line 0x80000000 still completes.
  - A new refill starts for 0x80000040 in the cycle after returning to IDLE.
- Reset mid-refill. Assert reset_n=0 after 2 acks.
  - mem_req_o=0 immediately.
  - After release, 0x80000000 misses (valid cleared).
